// File: rtl/branch_predict_resolve.sv
// branch_predict_resolve: bimodal 2-bit counter branch predictor with resolution, training and one-cycle mispredict redirect
module branch_predict_resolve #(
  parameter int IDX_BITS = 6,
  parameter logic [1:0] CTR_INIT = 2'b01
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pred_valid,
  input  logic [31:0] pred_pc,
  output logic        pred_taken,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_br_en,
  input  logic        res_pred_taken,
  input  logic [31:0] res_target,
  input  logic        flush,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] br_count,
  output logic [31:0] mp_count
);
  logic [1:0] ctr [2**IDX_BITS];
  logic [IDX_BITS-1:0] pidx, ridx;
  logic accept, miss;
  logic [1:0] cur, nxt;
  logic unused;
  assign unused = ^{pred_pc[31:IDX_BITS+2], pred_pc[1:0]};
  always_comb begin
    pidx = pred_pc[IDX_BITS+1:2];
    ridx = res_pc[IDX_BITS+1:2];
    accept = res_valid & ~flush;
    miss = res_br_en ^ res_pred_taken;
    cur = ctr[ridx];
    nxt = res_br_en ? (cur == 2'b11 ? cur : cur + 2'b01) : (cur == 2'b00 ? cur : cur - 2'b01);
    pred_taken = pred_valid & ctr[pidx][1];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < 2**IDX_BITS; i++) ctr[i] <= CTR_INIT;
      mispredict <= 1'b0;
      redirect_pc <= '0;
      br_count <= '0;
      mp_count <= '0;
    end else begin
      mispredict <= accept & miss;
      if (accept) begin
        ctr[ridx] <= nxt;
        redirect_pc <= res_br_en ? res_target : res_pc + 32'd4;
        br_count <= br_count + 32'd1;
        mp_count <= mp_count + {31'd0, miss};
      end
    end
endmodule
